// File: rtl/nic_buffered.sv
// nic_buffered: processor register port <-> ring-router PE port NIC
// with DEPTH-entry inbound (IF) and outbound (OF) packet FIFOs.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   addr            00 in-data, 01 in-status, 10 out-data, 11 out-status
//   d_in            processor write data
//   nicEN, nicWrEn  access enable, 1 = write / 0 = read
//   d_out           registered read data (1-cycle latency)
//   net_so/net_ro   outbound valid / router ready
//   net_do          outbound packet (OF head)
//   net_polarity    current router VC phase
//   net_si/net_ri   inbound valid / NIC ready
//   net_di          inbound packet
module nic_buffered #(
    parameter int DW     = 64,
    parameter int DEPTH  = 4,
    parameter int VC_BIT = DW - 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    addr,
    input  logic [DW-1:0] d_in,
    input  logic          nicEN,
    input  logic          nicWrEn,
    output logic [DW-1:0] d_out,
    output logic          net_so,
    input  logic          net_ro,
    output logic [DW-1:0] net_do,
    input  logic          net_polarity,
    input  logic          net_si,
    output logic          net_ri,
    input  logic [DW-1:0] net_di
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] if_mem [0:DEPTH-1];
    logic [DW-1:0] of_mem [0:DEPTH-1];

    logic [AW-1:0] if_rd, if_wr, of_rd, of_wr;
    logic [CW-1:0] if_cnt, of_cnt;
    logic          ovf;

    logic          if_full, if_empty, of_full, of_empty;
    logic          rd_en, wr_en;
    logic          if_push, if_pop, of_push, of_pop, of_drop;
    logic [DW-1:0] of_head;
    logic [DW-1:0] rd_data;

    assign if_full  = (if_cnt == CW'(DEPTH));
    assign if_empty = (if_cnt == '0);
    assign of_full  = (of_cnt == CW'(DEPTH));
    assign of_empty = (of_cnt == '0);

    assign rd_en = nicEN & ~nicWrEn;
    assign wr_en = nicEN & nicWrEn;

    assign net_ri  = ~if_full;
    assign if_push = net_si & net_ri;
    assign if_pop  = rd_en & (addr == 2'b00) & ~if_empty;

    assign of_push = wr_en & (addr == 2'b10) & ~of_full;
    assign of_drop = wr_en & (addr == 2'b10) & of_full;

    // Head-of-line gating: the head only leaves in its own VC phase.
    assign of_head = of_mem[of_rd];
    assign net_do  = of_head;
    assign net_so  = ~of_empty & net_ro
                   & (of_head[VC_BIT] == net_polarity);
    assign of_pop  = net_so;

    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            unique case (addr)
                2'b00: if (!if_empty) rd_data = if_mem[if_rd];
                2'b01: begin
                    rd_data[15:8] = 8'(if_cnt);
                    rd_data[0]    = ~if_empty;
                end
                2'b11: begin
                    rd_data[15:8] = 8'(of_cnt);
                    rd_data[1]    = ovf;
                    rd_data[0]    = of_full;
                end
                default: rd_data = '0;
            endcase
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (if_push) if_mem[if_wr] <= net_di;
        if (of_push) of_mem[of_wr] <= d_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_rd  <= '0;
            if_wr  <= '0;
            if_cnt <= '0;
            of_rd  <= '0;
            of_wr  <= '0;
            of_cnt <= '0;
            ovf    <= 1'b0;
            d_out  <= '0;
        end else begin
            d_out <= rd_data;
            if (if_push) if_wr <= if_wr + 1'b1;
            if (if_pop)  if_rd <= if_rd + 1'b1;
            if (of_push) of_wr <= of_wr + 1'b1;
            if (of_pop)  of_rd <= of_rd + 1'b1;
            unique case ({if_push, if_pop})
                2'b10:   if_cnt <= if_cnt + 1'b1;
                2'b01:   if_cnt <= if_cnt - 1'b1;
                default: if_cnt <= if_cnt;
            endcase
            unique case ({of_push, of_pop})
                2'b10:   of_cnt <= of_cnt + 1'b1;
                2'b01:   of_cnt <= of_cnt - 1'b1;
                default: of_cnt <= of_cnt;
            endcase
            // A drop beats a same-cycle status-read clear.
            if (of_drop)
                ovf <= 1'b1;
            else if (rd_en && addr == 2'b11)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nic_buffered.sv
// tb_nic_buffered: scoreboard bench for nic_buffered (DW=64, DEPTH=4).
// Expected reads and outbound packets are queued when driven.
module tb_nic_buffered;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  addr = '0;
    logic [63:0] d_in = '0;
    logic        nicEN = 1'b0;
    logic        nicWrEn = 1'b0;
    logic [63:0] d_out;
    logic        net_so;
    logic        net_ro = 1'b0;
    logic [63:0] net_do;
    logic        net_polarity = 1'b0;
    logic        net_si = 1'b0;
    logic        net_ri;
    logic [63:0] net_di = '0;

    nic_buffered #(.DW(64), .DEPTH(4), .VC_BIT(63)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in),
        .nicEN(nicEN), .nicWrEn(nicWrEn), .d_out(d_out),
        .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity), .net_si(net_si),
        .net_ri(net_ri), .net_di(net_di)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [63:0] iq[$];
    logic [63:0] oq[$];
    logic [63:0] sb[$];
    bit ovf_m = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outbound monitor: every departure must match the queued head.
    always @(negedge clk) begin
        logic [63:0] h;
        if (!reset && net_so) begin
            if (oq.size() == 0) begin
                chk("so_spurious", {63'b0, net_so}, 64'd0);
            end else begin
                h = oq.pop_front();
                chk("net_do", net_do, h);
            end
        end
    end

    task automatic cyc(input string tag, input logic si,
                       input logic [63:0] di, input logic en,
                       input logic we, input logic [1:0] a,
                       input logic [63:0] wd);
        int ic;
        int oc;
        logic [63:0] e;
        ic = iq.size();
        oc = oq.size();
        net_si = si;
        net_di = di;
        nicEN = en;
        nicWrEn = we;
        addr = a;
        d_in = wd;
        #1;
        chk({tag, "_ri"}, {63'b0, net_ri}, {63'b0, ic < 4});
        e = '0;
        if (en && !we) begin
            case (a)
                2'b00: e = (ic != 0) ? iq.pop_front() : 64'd0;
                2'b01: e = (64'(ic) << 8) | 64'(ic != 0);
                2'b11: begin
                    e = (64'(oc) << 8) | (64'(ovf_m) << 1)
                      | 64'(oc == 4);
                    ovf_m = 1'b0;
                end
                default: e = '0;
            endcase
        end
        if (en && we && a == 2'b10) begin
            if (oc < 4) oq.push_back(wd);
            else ovf_m = 1'b1;
        end
        if (si && ic < 4) iq.push_back(di);
        sb.push_back(e);
        step();
        net_si = 1'b0;
        nicEN = 1'b0;
        nicWrEn = 1'b0;
        chk({tag, "_dout"}, d_out, sb.pop_front());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        net_si = 1'b0;
        nicEN = 1'b0;
        net_ro = 1'b0;
        step();
        step();
        chk("rst_dout", d_out, 64'd0);
        chk("rst_so", {63'b0, net_so}, 64'd0);
        chk("rst_ri", {63'b0, net_ri}, 64'd1);
        reset = 1'b0;
        iq.delete();
        oq.delete();
        sb.delete();
        ovf_m = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Inbound fill and drain
        for (int i = 1; i <= 4; i++)
            cyc("fill", 1'b1, 64'(i * 'h11), 1'b0, 1'b0, 2'b00, 0);
        cyc("full", 1'b1, 64'h55, 1'b0, 1'b0, 2'b00, 0);
        cyc("istat", 1'b1, 64'h55, 1'b1, 1'b0, 2'b01, 0);
        chk("istat_const", d_out, 64'h401);
        for (int i = 0; i < 5; i++)
            cyc("drain", 1'b0, 0, 1'b1, 1'b0, 2'b00, 0);
        chk("drain_empty", d_out, 64'd0);

        // Overflow
        for (int i = 1; i <= 5; i++)
            cyc("owr", 1'b0, 0, 1'b1, 1'b1, 2'b10, 64'h200 + 64'(i));
        cyc("ostat1", 1'b0, 0, 1'b1, 1'b0, 2'b11, 0);
        chk("ostat1_const", d_out, 64'h403);
        cyc("ostat2", 1'b0, 0, 1'b1, 1'b0, 2'b11, 0);
        chk("ostat2_const", d_out, 64'h401);
        cyc("rd10", 1'b0, 0, 1'b1, 1'b0, 2'b10, 0);

        // Full OF: write and pop in the same cycle
        net_polarity = 1'b0;
        net_ro = 1'b1;
        cyc("ovf_cc", 1'b0, 0, 1'b1, 1'b1, 2'b10, 64'h2FF);
        net_ro = 1'b0;
        cyc("ostat3", 1'b0, 0, 1'b1, 1'b0, 2'b11, 0);
        chk("ostat3_const", d_out, 64'h302);
        net_ro = 1'b1;
        for (int i = 0; i < 3; i++)
            cyc("odrain", 1'b0, 0, 1'b0, 1'b0, 2'b00, 0);
        chk("so_empty", {63'b0, net_so}, 64'd0);
        net_ro = 1'b0;
        cyc("ostat4", 1'b0, 0, 1'b1, 1'b0, 2'b11, 0);

        // IF at 2: push and pop together
        cyc("if2a", 1'b1, 64'h61, 1'b0, 1'b0, 2'b00, 0);
        cyc("if2b", 1'b1, 64'h62, 1'b0, 1'b0, 2'b00, 0);
        cyc("if2cc", 1'b1, 64'h63, 1'b1, 1'b0, 2'b00, 0);
        cyc("if2st", 1'b0, 0, 1'b1, 1'b0, 2'b01, 0);
        chk("if2st_const", d_out, 64'h201);
        cyc("if2d1", 1'b0, 0, 1'b1, 1'b0, 2'b00, 0);
        cyc("if2d2", 1'b0, 0, 1'b1, 1'b0, 2'b00, 0);

        // Polarity gating, head-of-line order
        cyc("pw0", 1'b0, 0, 1'b1, 1'b1, 2'b10, 64'h8000_0000_0000_00A0);
        cyc("pw1", 1'b0, 0, 1'b1, 1'b1, 2'b10, 64'h0000_0000_0000_00B0);
        net_polarity = 1'b0;
        net_ro = 1'b1;
        #1;
        chk("pol_block", {63'b0, net_so}, 64'd0);
        cyc("pidle", 1'b0, 0, 1'b0, 1'b0, 2'b00, 0);
        chk("pol_block2", {63'b0, net_so}, 64'd0);
        net_polarity = 1'b1;
        #1;
        chk("pol_p0", {63'b0, net_so}, 64'd1);
        cyc("pgo0", 1'b0, 0, 1'b0, 1'b0, 2'b00, 0);
        chk("pol_p1wait", {63'b0, net_so}, 64'd0);
        net_polarity = 1'b0;
        #1;
        chk("pol_p1", {63'b0, net_so}, 64'd1);
        cyc("pgo1", 1'b0, 0, 1'b0, 1'b0, 2'b00, 0);
        chk("pol_done", {63'b0, net_so}, 64'd0);
        chk("pol_sb", 64'(oq.size()), 64'd0);
        net_ro = 1'b0;

        // Wrap-around streaming
        for (int i = 0; i < 13; i++)
            cyc("wrap", 1'b1, 64'h1000 + 64'(i), 1'b1, 1'b0, 2'b00, 0);
        cyc("wrapl", 1'b0, 0, 1'b1, 1'b0, 2'b00, 0);
        cyc("wrapst", 1'b0, 0, 1'b1, 1'b0, 2'b01, 0);

        // Reset mid-traffic
        cyc("mt_i0", 1'b1, 64'h71, 1'b0, 1'b0, 2'b00, 0);
        cyc("mt_i1", 1'b1, 64'h72, 1'b1, 1'b1, 2'b10, 64'h81);
        cyc("mt_o1", 1'b0, 0, 1'b1, 1'b1, 2'b10, 64'h82);
        do_reset();
        cyc("rst_is", 1'b0, 0, 1'b1, 1'b0, 2'b01, 0);
        chk("rst_is_const", d_out, 64'h0);
        cyc("rst_os", 1'b0, 0, 1'b1, 1'b0, 2'b11, 0);
        chk("rst_os_const", d_out, 64'h0);
        cyc("rst_id", 1'b0, 0, 1'b1, 1'b0, 2'b00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nic_buffered.md
# nic_buffered

Parametrised network interface controller joining a processor register port to one ring-router PE port. It buffers traffic in two DEPTH-entry FIFOs: network-to-processor and processor-to-network. It exposes occupancy and overflow status, and releases outbound packets only when the head packet's virtual-channel bit matches the router's current polarity. It replaces the fixed single-slot NIC inside the node top, with the same processor and router handshakes.

## Interface
- DW, 64, packet and processor data width (≥16).
- DEPTH, 4, entries per FIFO; power of two, ≥2.
- VC_BIT, DW-1, bit of each packet carrying its virtual channel (even/odd polarity).
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  2  register select: 00 in-data, 01 in-status, 10 out-data, 11 out-status.
- d_in  in  DW  processor write data.
- nicEN  in  1  register access enable.
- nicWrEn  in  1  1 = write, 0 = read (qualified by nicEN).
- d_out  out  DW  registered read data.
- net_so  out  1  send valid to router.
- net_ro  in  1  router ready to accept.
- net_do  out  DW  outbound packet (output FIFO head).
- net_polarity  in  1  router polarity (current VC phase).
- net_si  in  1  router send valid into NIC.
- net_ri  out  1  NIC ready to accept from router.
- net_di  in  DW  inbound packet.

## Operation
- The input FIFO (IF) and output FIFO (OF) are each a circular buffer with rd/wr pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - Each has a count of log2(DEPTH)+1 bits, range 0..DEPTH.
  - Full/empty are derived from the pre-edge count.
- **Inbound path.**
  - net_ri = (IF count < DEPTH).
  - Push net_di on a cycle where net_si & net_ri.
- **Processor read, addr 00** (nicEN & !nicWrEn):
  - IF non-empty: d_out ← IF head and pop.
  - IF empty: d_out ← 0, no pop.
- **Processor read, addr 01:** d_out ← zero-extended {IF count at bits[15:8], IF non-empty at bit0}; other bits 0.
- **Processor write, addr 10** (nicEN & nicWrEn):
  - OF not full: push d_in.
  - OF full: data dropped, sticky ovf flag set.
- **Processor read, addr 11:** d_out ← {OF count at bits[15:8], ovf at bit1, OF full at bit0}. The read clears ovf at the same edge; a drop in the same cycle wins and leaves ovf = 1.
- **Ignored accesses:**
  - Writes to addr 00/01/11 are ignored.
  - Reads of addr 10 return 0.
  - Cycles with nicEN = 0 load d_out ← 0.
- **Outbound path.**
  - net_do = OF head.
  - net_so = OF non-empty & net_ro & (head[VC_BIT] == net_polarity).
  - OF pops on net_so.
  - Head-of-line blocking is intentional: a mismatched head waits for the polarity flip and later packets never bypass it.
- **Simultaneous events.**
  - Push and pop on the same FIFO in one cycle both occur and the count is unchanged.
  - A push to a full FIFO is refused even if a pop occurs in the same cycle, because the decision uses the pre-edge count.
  - A pop from an empty FIFO never occurs, so pointers never underflow.
- **Reset.**
  - Pointers, counts, ovf and d_out go to 0. FIFO storage is not cleared and is don't-care.
  - Reset mid-operation discards all buffered packets.
  - First post-reset outputs: net_ri = 1, net_so = 0.

## Timing
- d_out has 1-cycle latency: the request is sampled at edge N and the data is valid after edge N until edge N+1.
- net_ri is combinational from registered count only.
- net_so is combinational from count, head, net_ro and net_polarity, so net_ro → net_so is a same-cycle path.
- Status reflects all pushes and pops up to the edge preceding the read request.
  - Example: a packet pushed at edge N is counted by a status read requested in cycle N+1.
- IF-to-processor minimum latency: packet pushed at edge N, data read requested in cycle N+1, d_out valid after edge N+1.
- Throughput is one packet per cycle per direction, sustained indefinitely when not blocked.

## Test plan
- **Reset:** assert reset for 2 cycles mid-traffic with DEPTH=4 → d_out=0, net_so=0, net_ri=1, statuses read 0x0 (addr 01) and 0x0 (addr 11).
- **Inbound fill:** router sends 0x11..0x44 on consecutive cycles → net_ri drops after the 4th; in-status reads 0x401; 0x55 held with net_si is not accepted. Four addr-00 reads return 0x11, 0x22, 0x33, 0x44; the fifth returns 0.
- **Overflow:** write 5 packets to addr 10 with net_ro=0 → out-status reads 0x403 (count 4, ovf, full); the next out-status read returns 0x401.
- **Polarity gating:** OF holds P0 with VC_BIT=1, then P1 with VC_BIT=0; polarity=0, net_ro=1 → net_so=0. Polarity→1: P0 leaves with net_so=1 for that cycle. Polarity→0: P1 leaves, in order.
- **Concurrent traffic:** with the OF full, a processor write and an accepting pop in the same cycle → the write is dropped and ovf=1. With the IF at 2, simultaneous net push and processor pop → count stays 2.
- **Wrap-around:** stream 3·DEPTH+1 inbound packets, reading each as it arrives → data order preserved across pointer wraps, with no spurious full/empty.
